// File: rtl/key_bit_sampler.sv
// rtl/key_bit_sampler.sv - debounced pushbutton strobe and switch-bit sampler
module key_bit_sampler #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int HIST_W          = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              key_n,
   input  logic              sw_w,
   output logic              enable,
   output logic              w,
   output logic [HIST_W-1:0] history,
   output logic [7:0]        sample_count,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   // Terminal count: the level must be seen this many cycles in a row.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic              key_meta;
   logic              key_s;
   logic              sw_meta;
   logic              sw_s;

   state_t            state_q;
   state_t            state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              accept;

   logic              enable_q;
   logic              w_q;
   logic [HIST_W-1:0] history_q;
   logic [7:0]        count_q;

   // Two-flop synchronizers; the key idles released (1) so reset never looks like a press.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_meta <= 1'b1;
         key_s    <= 1'b1;
         sw_meta  <= 1'b0;
         sw_s     <= 1'b0;
      end else begin
         key_meta <= key_n;
         key_s    <= key_meta;
         sw_meta  <= sw_w;
         sw_s     <= sw_meta;
      end
   end

   // Debounce FSM state and stability counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; accept fires on the single edge that confirms a press.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!key_s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (key_s) begin
               // Low level did not last long enough: treat as a glitch.
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (key_s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!key_s) begin
               // Contact bounce on release: back to held without a new strobe.
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output datapath: strobe, sampled bit, history shift and press counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         enable_q  <= 1'b0;
         w_q       <= 1'b0;
         history_q <= '0;
         count_q   <= 8'd0;
      end else begin
         enable_q <= accept;
         if (accept) begin
            w_q       <= sw_s;
            history_q <= {history_q[HIST_W-2:0], sw_s};
            count_q   <= count_q + 8'd1;
         end
      end
   end

   assign enable       = enable_q;
   assign w            = w_q;
   assign history      = history_q;
   assign sample_count = count_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_key_bit_sampler.sv
// tb/tb_key_bit_sampler.sv - scoreboard bench for key_bit_sampler
module tb_key_bit_sampler;

   logic       clock;
   logic       reset;
   logic       key_n;
   logic       sw_w;
   logic       enable;
   logic       w;
   logic [7:0] history;
   logic [7:0] sample_count;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int         c;
      logic       b;
      logic [7:0] h;
      logic [7:0] n;
   } exp_t;

   exp_t       q[$];
   logic [7:0] model_hist = 8'h00;
   logic [7:0] model_cnt  = 8'h00;

   key_bit_sampler #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(20),
      .HIST_W(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .key_n(key_n),
      .sw_w(sw_w),
      .enable(enable),
      .w(w),
      .history(history),
      .sample_count(sample_count),
      .dbg_state(dbg_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge on which key_n has just been driven low: first sample at cyc+1, strobe visible at cyc+7.
   task automatic expect_strobe(input logic b);
      exp_t e;
      model_hist = {model_hist[6:0], b};
      model_cnt  = model_cnt + 8'd1;
      e.c = cyc + 7;
      e.b = b;
      e.h = model_hist;
      e.n = model_cnt;
      q.push_back(e);
   endtask

   task automatic press(input logic b, input int hold, input int rel);
      @(negedge clock);
      sw_w  = b;
      key_n = 1'b0;
      expect_strobe(b);
      repeat (hold) @(negedge clock);
      key_n = 1'b1;
      repeat (rel) @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      model_hist = 8'h00;
      model_cnt  = 8'h00;
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (reset && enable) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got enable=1 expected none (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("strobe_cycle", cyc, e.c);
            chk("strobe_w", {31'd0, w}, {31'd0, e.b});
            chk("strobe_history", {24'd0, history}, {24'd0, e.h});
            chk("strobe_count", {24'd0, sample_count}, {24'd0, e.n});
         end
      end
   end

   initial begin
      reset = 1'b0;
      key_n = 1'b1;
      sw_w  = 1'b1;
      repeat (3) @(negedge clock);
      chk("reset_enable", {31'd0, enable}, 32'd0);
      chk("reset_dbg", {30'd0, dbg_state}, 32'd0);
      reset = 1'b1;

      // 1: idle with key released
      repeat (20) @(negedge clock);
      chk("idle_w", {31'd0, w}, 32'd0);
      chk("idle_history", {24'd0, history}, 32'h00);
      chk("idle_count", {24'd0, sample_count}, 32'd0);
      chk("idle_dbg", {30'd0, dbg_state}, 32'd0);

      // 2: single clean press with sw=1
      @(negedge clock);
      sw_w  = 1'b1;
      key_n = 1'b0;
      expect_strobe(1'b1);
      repeat (10) @(negedge clock);
      chk("held_dbg", {30'd0, dbg_state}, 32'd2);
      repeat (10) @(negedge clock);
      key_n = 1'b1;
      repeat (10) @(negedge clock);
      chk("p2_w", {31'd0, w}, 32'd1);
      chk("p2_history", {24'd0, history}, 32'h01);
      chk("p2_count", {24'd0, sample_count}, 32'd1);
      chk("p2_dbg_released", {30'd0, dbg_state}, 32'd0);

      // 3: five 3-cycle bounces, none accepted
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         key_n = 1'b0;
         repeat (3) @(negedge clock);
         key_n = 1'b1;
         repeat (4) @(negedge clock);
         chk("bounce_dbg_idle", {30'd0, dbg_state}, 32'd0);
      end
      chk("bounce_count", {24'd0, sample_count}, 32'd1);

      // 4: eight clean presses after a fresh reset
      do_reset();
      repeat (3) @(negedge clock);
      chk("reset2_history", {24'd0, history}, 32'h00);
      begin
         logic [7:0] bits;
         bits = 8'b1101_0000;
         for (int i = 7; i >= 0; i--) press(bits[i], 8, 10);
      end
      chk("p4_history", {24'd0, history}, 32'hD0);
      chk("p4_count", {24'd0, sample_count}, 32'd8);
      chk("p4_w", {31'd0, w}, 32'd0);

      // 5: release bounce mid-hold, and sw change while held
      @(negedge clock);
      sw_w  = 1'b1;
      key_n = 1'b0;
      expect_strobe(1'b1);
      repeat (10) @(negedge clock);
      sw_w  = 1'b0;
      key_n = 1'b1;
      repeat (2) @(negedge clock);
      key_n = 1'b0;
      repeat (6) @(negedge clock);
      chk("rel_bounce_dbg", {30'd0, dbg_state}, 32'd2);
      chk("rel_bounce_w_held", {31'd0, w}, 32'd1);
      key_n = 1'b1;
      repeat (10) @(negedge clock);
      chk("p5_count", {24'd0, sample_count}, 32'd9);
      chk("p5_history", {24'd0, history}, 32'hA1);
      chk("p5_dbg", {30'd0, dbg_state}, 32'd0);

      // 6: reset during PRESS_WAIT, key still held across release
      @(negedge clock);
      sw_w  = 1'b1;
      key_n = 1'b0;
      repeat (5) @(negedge clock);
      chk("pw_dbg", {30'd0, dbg_state}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_enable", {31'd0, enable}, 32'd0);
      chk("async_w", {31'd0, w}, 32'd0);
      chk("async_history", {24'd0, history}, 32'h00);
      chk("async_count", {24'd0, sample_count}, 32'd0);
      chk("async_dbg", {30'd0, dbg_state}, 32'd0);
      model_hist = 8'h00;
      model_cnt  = 8'h00;
      @(negedge clock);
      reset = 1'b1;
      expect_strobe(1'b1);
      repeat (12) @(negedge clock);
      chk("post_reset_count", {24'd0, sample_count}, 32'd1);
      key_n = 1'b1;
      repeat (10) @(negedge clock);
      for (int i = 0; i < 256; i++) press(i[0], 7, 9);
      chk("wrap_count", {24'd0, sample_count}, 32'd1);

      repeat (20) @(negedge clock);
      chk("pending_strobes", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
